// File: rtl/systolic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared sizes, element/vector/matrix types and controller
//             state encoding for the systolic array and its controller.
//  Revision : 1.0  initial release
// ============================================================================
package systolic_pkg;

  localparam int N         = 4;
  localparam int NUM_BITS  = 8;
  localparam int DRAIN_CYC = 2 * N - 1;

  // Counter widths: beat counter spans 0..N-1, drain counter spans 0..DRAIN_CYC
  localparam int BEAT_W    = (N > 1) ? $clog2(N) : 1;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);

  typedef logic [NUM_BITS-1:0] elem_t;
  typedef elem_t [N-1:0]       vec_t;
  typedef vec_t  [N-1:0]       mat_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_ctrl_if
//  Purpose  : Host-side bundle of the systolic controller: job start/busy,
//             operand beat handshake and result handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface systolic_ctrl_if;
  import systolic_pkg::*;

  logic start_i;
  logic busy_o;
  logic op_valid_i;
  logic op_ready_o;
  vec_t a_col_i;
  vec_t b_row_i;
  mat_t C_o;
  logic res_valid_o;
  logic res_ready_i;

  // Host side: issues jobs, supplies operands, consumes the result
  modport master (
    output start_i, op_valid_i, a_col_i, b_row_i, res_ready_i,
    input  busy_o, op_ready_o, C_o, res_valid_o
  );

  // Controller side
  modport slave (
    input  start_i, op_valid_i, a_col_i, b_row_i, res_ready_i,
    output busy_o, op_ready_o, C_o, res_valid_o
  );

endinterface
`default_nettype wire

// File: rtl/systolic_ctrl_skew_lane.sv
`default_nettype none
// ============================================================================
//  Module   : skew_lane
//  Purpose  : Fixed-depth delay line for one array edge lane, with a
//             synchronous clear that flushes every stage to zero.
//  Revision : 1.0  initial release
// ============================================================================
module skew_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  // Shift register: stage 0 takes the new sample, the last stage drives the lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else if (clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_ctrl
//  Purpose  : Job sequencer for the NxN output-stationary systolic array.
//             Clears the accumulators, streams skewed operand beats into the
//             array edges, waits out the drain latency and holds the latched
//             result under a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_ctrl
  import systolic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_ctrl_if.slave        host,
  output vec_t                  west_o,
  output vec_t                  north_o,
  output logic                  clr_o,
  input  mat_t                  C_i
);

  ctrl_state_e        r_state;
  ctrl_state_e        w_state_nxt;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic [BEAT_W-1:0]  w_beat_cnt_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_cnt_nxt;
  logic               w_latch;
  logic               w_accept;
  logic               w_clr;
  vec_t               w_a_in;
  vec_t               w_b_in;
  mat_t               r_c;

  // A beat is taken only while streaming; op_ready is the STREAM decode
  assign w_accept = (r_state == S_STREAM) && host.op_valid_i;
  assign w_clr    = (r_state == S_CLEAR);

  // Bubbles feed zeros into every lane so stalls stay lane-aligned
  assign w_a_in = w_accept ? host.a_col_i : '0;
  assign w_b_in = w_accept ? host.b_row_i : '0;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Next-state, counter update and result-latch decision
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_latch         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (host.start_i) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_beat_cnt_nxt  = '0;
        w_drain_cnt_nxt = '0;
        w_state_nxt     = S_STREAM;
      end
      S_STREAM: begin
        if (host.op_valid_i) begin
          if (r_beat_cnt == BEAT_W'(N - 1)) begin
            w_beat_cnt_nxt  = '0;
            w_drain_cnt_nxt = '0;
            w_state_nxt     = S_DRAIN;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Counter spans DRAIN_CYC zero-feed cycles; the latch follows on the
        // next edge, once the last diagonal product has reached C_i
        if (r_drain_cnt == DRAIN_W'(DRAIN_CYC)) begin
          w_latch         = 1'b1;
          w_drain_cnt_nxt = '0;
          w_state_nxt     = S_DONE;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 1'b1;
        end
      end
      S_DONE: begin
        // A start seen here together with ready is dropped, not queued
        if (host.res_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Result register, loaded once per job and held through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= '0;
    end else if (w_latch) begin
      r_c <= C_i;
    end
  end

  // Lane i of each edge is delayed i+1 registers to form the diagonal wavefront
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    skew_lane #(
      .DEPTH (gi + 1),
      .WIDTH (NUM_BITS)
    ) u_west (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .din   (w_a_in[gi]),
      .dout  (west_o[gi])
    );

    skew_lane #(
      .DEPTH (gi + 1),
      .WIDTH (NUM_BITS)
    ) u_north (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .din   (w_b_in[gi]),
      .dout  (north_o[gi])
    );
  end

  assign clr_o            = w_clr;
  assign host.busy_o      = (r_state != S_IDLE);
  assign host.op_ready_o  = (r_state == S_STREAM);
  assign host.res_valid_o = (r_state == S_DONE);
  assign host.C_o         = r_c;

endmodule
`default_nettype wire
